// File: rtl/line_sched.sv
// line_sched: shares the render-resource port between the HBLANK ray tracer and
// the VBLANK config loader, and emits per-line and per-frame sequencing pulses.
module line_sched #(
  parameter logic [9:0] H_VIEW = 10'd640,
  parameter logic [9:0] H_MAX  = 10'd799,
  parameter logic [9:0] V_VIEW = 10'd480,
  parameter logic [9:0] V_MAX  = 10'd524
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       tr_req,
  input  logic       cfg_req,
  output logic       tr_gnt,
  output logic       cfg_gnt,
  output logic       tr_abort,
  output logic       cfg_abort,
  output logic       line_start,
  output logic [9:0] next_line,
  output logic       frame_end,
  output logic [7:0] overrun_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    CFG   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       trace_win, cfg_win;
  logic       tr_gnt_q, cfg_gnt_q;
  logic       tr_abort_q, tr_abort_d;
  logic       cfg_abort_q, cfg_abort_d;
  logic       line_start_q, line_start_d;
  logic       frame_end_q, frame_end_d;
  logic [9:0] next_line_q, next_line_d;
  logic [7:0] overrun_q, overrun_d;

  // The tracer works in the HBLANK of every line whose successor is visible
  // (including the last VBLANK line, which prepares line 0).
  assign trace_win = (hpos >= H_VIEW) && (hpos <= H_MAX) &&
                     ((vpos < (V_VIEW - 10'd1)) || (vpos == V_MAX));
  assign cfg_win   = (vpos >= V_VIEW) && !((vpos == V_MAX) && (hpos >= H_VIEW));

  // Arbitration, window enforcement and sequencing next-state.
  always_comb begin
    state_d      = state_q;
    tr_abort_d   = 1'b0;
    cfg_abort_d  = 1'b0;
    overrun_d    = overrun_q;
    line_start_d = (hpos == H_VIEW) && trace_win;
    frame_end_d  = (hpos == 10'd0) && (vpos == V_VIEW);
    if (line_start_d) begin
      next_line_d = (vpos == V_MAX) ? 10'd0 : (vpos + 10'd1);
    end else begin
      next_line_d = next_line_q;
    end
    case (state_q)
      IDLE: begin
        if (tr_req && trace_win) begin
          state_d = TRACE;
        end else if (cfg_req && cfg_win) begin
          state_d = CFG;
        end else begin
          state_d = IDLE;
        end
      end
      TRACE: begin
        if (!tr_req) begin
          state_d = IDLE;
        end else if (!trace_win) begin
          state_d    = IDLE;
          tr_abort_d = 1'b1;
          overrun_d  = (overrun_q == 8'hFF) ? overrun_q : (overrun_q + 8'd1);
        end else begin
          state_d = TRACE;
        end
      end
      CFG: begin
        if (!cfg_req) begin
          state_d = IDLE;
        end else if (!cfg_win) begin
          state_d     = IDLE;
          cfg_abort_d = 1'b1;
        end else begin
          state_d = CFG;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any grant without an abort pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tr_gnt_q     <= 1'b0;
      cfg_gnt_q    <= 1'b0;
      tr_abort_q   <= 1'b0;
      cfg_abort_q  <= 1'b0;
      line_start_q <= 1'b0;
      frame_end_q  <= 1'b0;
      next_line_q  <= 10'd0;
      overrun_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      tr_gnt_q     <= (state_d == TRACE);
      cfg_gnt_q    <= (state_d == CFG);
      tr_abort_q   <= tr_abort_d;
      cfg_abort_q  <= cfg_abort_d;
      line_start_q <= line_start_d;
      frame_end_q  <= frame_end_d;
      next_line_q  <= next_line_d;
      overrun_q    <= overrun_d;
    end
  end

  assign tr_gnt        = tr_gnt_q;
  assign cfg_gnt       = cfg_gnt_q;
  assign tr_abort      = tr_abort_q;
  assign cfg_abort     = cfg_abort_q;
  assign line_start    = line_start_q;
  assign frame_end     = frame_end_q;
  assign next_line     = next_line_q;
  assign overrun_count = overrun_q;

endmodule

// File: tb/tb_line_sched.sv
// Bench for line_sched: directed scenarios plus randomized requests, checked
// against a frame-position reference model.
module tb_line_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hpos = 10'd0;
  logic [9:0] vpos = 10'd0;
  logic       tr_req = 1'b0;
  logic       cfg_req = 1'b0;
  logic       tr_gnt, cfg_gnt, tr_abort, cfg_abort, line_start, frame_end;
  logic [9:0] next_line;
  logic [7:0] overrun_count;

  int vectors = 0;
  int miscompares = 0;

  // reference model: owner 0 = nobody, 1 = tracer, 2 = config loader
  int         owner = 0;
  int         e_cnt = 0;
  logic [9:0] e_next_line = 10'd0;
  int         ls_seen = 0;
  int         fe_seen = 0;

  always #5 clk = ~clk;

  line_sched dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .tr_req(tr_req), .cfg_req(cfg_req),
    .tr_gnt(tr_gnt), .cfg_gnt(cfg_gnt),
    .tr_abort(tr_abort), .cfg_abort(cfg_abort),
    .line_start(line_start), .next_line(next_line),
    .frame_end(frame_end), .overrun_count(overrun_count)
  );

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Predict the response to the current inputs, clock once, compare everything.
  task automatic tick();
    int nxt, p;
    bit tw, cw, e_ls, e_fe, e_ta, e_ca;
    nxt  = (int'(vpos) + 1) % 525;
    tw   = (hpos >= 10'd640) && (nxt < 480);
    p    = int'(vpos) * 800 + int'(hpos);
    cw   = (p >= 480 * 800) && (p < 524 * 800 + 640);
    e_ls = tw && (hpos == 10'd640);
    e_fe = (hpos == 10'd0) && (vpos == 10'd480);
    e_ta = 1'b0;
    e_ca = 1'b0;
    if (e_ls) e_next_line = 10'(nxt);
    case (owner)
      0: begin
        if (tr_req && tw) owner = 1;
        else if (cfg_req && cw) owner = 2;
      end
      1: begin
        if (!tr_req) owner = 0;
        else if (!tw) begin
          owner = 0;
          e_ta  = 1'b1;
          if (e_cnt < 255) e_cnt++;
        end
      end
      2: begin
        if (!cfg_req) owner = 0;
        else if (!cw) begin
          owner = 0;
          e_ca  = 1'b1;
        end
      end
      default: owner = 0;
    endcase
    if (reset) begin
      owner = 0; e_ls = 1'b0; e_fe = 1'b0; e_ta = 1'b0; e_ca = 1'b0;
      e_next_line = 10'd0; e_cnt = 0;
    end
    @(posedge clk);
    #1;
    chk("tr_gnt", 10'(tr_gnt), 10'(owner == 1));
    chk("cfg_gnt", 10'(cfg_gnt), 10'(owner == 2));
    chk("tr_abort", 10'(tr_abort), 10'(e_ta));
    chk("cfg_abort", 10'(cfg_abort), 10'(e_ca));
    chk("line_start", 10'(line_start), 10'(e_ls));
    chk("frame_end", 10'(frame_end), 10'(e_fe));
    chk("next_line", next_line, e_next_line);
    chk("overrun_count", 10'(overrun_count), 10'(e_cnt));
    chk("grant_exclusive", 10'(tr_gnt & cfg_gnt), 10'd0);
    if (line_start === 1'b1) ls_seen++;
    if (frame_end === 1'b1) fe_seen++;
  endtask

  task automatic adv();
    if (hpos == 10'd799) begin
      hpos = 10'd0;
      vpos = (vpos == 10'd524) ? 10'd0 : (vpos + 10'd1);
    end else begin
      hpos = hpos + 10'd1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      adv();
    end
  endtask

  task automatic set_pos(input logic [9:0] h, input logic [9:0] v);
    hpos = h;
    vpos = v;
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    run(2);
    reset = 1'b0;

    // one frame, visiting the start of each line and its HBLANK entry
    ls_seen = 0;
    fe_seen = 0;
    for (int v = 0; v < 525; v++) begin
      set_pos(10'd0, 10'(v));
      run(2);
      set_pos(10'd638, 10'(v));
      run(4);
    end
    chk("frame_line_starts", 10'(ls_seen), 10'd480);
    chk("frame_end_count", 10'(fe_seen), 10'd1);
    chk("frame_last_next_line", next_line, 10'd0);

    // normal trace with release, then immediate re-request
    set_pos(10'd639, 10'd10);
    run(1);
    tr_req = 1'b1;
    tick();
    chk("nt_grant", 10'(tr_gnt), 10'd1);
    adv();
    run(59);
    tr_req = 1'b0;
    tick();
    chk("nt_release", 10'(tr_gnt), 10'd0);
    chk("nt_no_abort", 10'(tr_abort), 10'd0);
    adv();
    tr_req = 1'b1;
    tick();
    chk("nt_regrant", 10'(tr_gnt), 10'd1);
    adv();
    tr_req = 1'b0;
    run(2);

    // trace overrun, then saturate the counter
    tr_req = 1'b1;
    set_pos(10'd640, 10'd20);
    run(2);
    set_pos(10'd798, 10'd20);
    run(2);
    tick();
    chk("ov_abort", 10'(tr_abort), 10'd1);
    chk("ov_gnt_low", 10'(tr_gnt), 10'd0);
    chk("ov_count1", 10'(overrun_count), 10'd1);
    adv();
    for (int i = 0; i < 300; i++) begin
      set_pos(10'd640, 10'(22 + i));
      run(1);
      set_pos(10'd799, 10'(22 + i));
      run(2);
    end
    chk("ov_saturated", 10'(overrun_count), 10'd255);

    // reset in the middle of a grant
    set_pos(10'd640, 10'd50);
    run(20);
    chk("rst_pre_gnt", 10'(tr_gnt), 10'd1);
    reset = 1'b1;
    tick();
    chk("rst_gnt_low", 10'(tr_gnt), 10'd0);
    chk("rst_no_abort", 10'(tr_abort), 10'd0);
    chk("rst_count", 10'(overrun_count), 10'd0);
    chk("rst_next_line", next_line, 10'd0);
    reset = 1'b0;
    adv();

    // one abort, then release in the very cycle the window closes
    set_pos(10'd640, 10'd60);
    run(1);
    set_pos(10'd799, 10'd60);
    run(2);
    set_pos(10'd640, 10'd62);
    run(1);
    set_pos(10'd799, 10'd62);
    run(1);
    tr_req = 1'b0;
    tick();
    chk("race_no_abort", 10'(tr_abort), 10'd0);
    chk("race_count", 10'(overrun_count), 10'd1);
    adv();

    // config loader waits for VBLANK, is cut off, tracer takes over
    cfg_req = 1'b1;
    set_pos(10'd0, 10'd100);
    run(3);
    chk("cfg_wait", 10'(cfg_gnt), 10'd0);
    set_pos(10'd798, 10'd479);
    run(2);
    tick();
    chk("cfg_grant", 10'(cfg_gnt), 10'd1);
    adv();
    set_pos(10'd630, 10'd524);
    run(10);
    tr_req = 1'b1;
    tick();
    chk("cfg_abort", 10'(cfg_abort), 10'd1);
    chk("cfg_gnt_low", 10'(cfg_gnt), 10'd0);
    chk("cfg_tr_idle", 10'(tr_gnt), 10'd0);
    adv();
    tick();
    chk("cfg_then_tr", 10'(tr_gnt), 10'd1);
    chk("cfg_count_same", 10'(overrun_count), 10'd1);
    adv();
    tr_req = 1'b0;
    cfg_req = 1'b0;
    run(2);

    // randomized requests around the window edges
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: set_pos(10'($urandom_range(636, 644)), 10'($urandom_range(0, 524)));
          1: set_pos(10'($urandom_range(796, 799)), 10'($urandom_range(476, 482)));
          2: set_pos(10'($urandom_range(630, 650)), 10'd524);
          default: set_pos(10'($urandom_range(796, 799)), 10'($urandom_range(0, 524)));
        endcase
      end
      if ($urandom_range(0, 7) == 0) tr_req = ~tr_req;
      if ($urandom_range(0, 7) == 0) cfg_req = ~cfg_req;
      reset = ($urandom_range(0, 499) == 0);
      tick();
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_sched.md
Name: line_sched

Overview:
- Scheduler/arbiter driven by the VGA timing generator's hpos/vpos.
- Shares one render-resource port (map/texture memory plus the tracer datapath) between two requesters:
  - the per-line ray tracer, which prepares the next visible line during HBLANK;
  - the config loader, which applies register updates during VBLANK.
- Emits per-line and per-frame sequencing pulses.
- Enforces each requester's blanking window, forcibly revoking a grant that overruns it.

Parameters:
- H_VIEW, 640, first hblank column
- H_MAX, 799, last column of a line
- V_VIEW, 480, first vblank line
- V_MAX, 524, last line of a frame

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- hpos  in  10  current column from timing generator
- vpos  in  10  current line from timing generator
- tr_req  in  1  tracer requests port; held high until its work is done
- cfg_req  in  1  config loader requests port; held high until done
- tr_gnt  out  1  tracer owns port
- cfg_gnt  out  1  config loader owns port
- tr_abort  out  1  one-cycle pulse: tracer grant revoked by window close
- cfg_abort  out  1  one-cycle pulse: config grant revoked by window close
- line_start  out  1  one-cycle pulse: trace window for next line opened
- next_line  out  10  index of line being prepared; valid with line_start, held until next line_start
- frame_end  out  1  one-cycle pulse at VBLANK entry
- overrun_count  out  8  saturating count of tracer aborts

Behaviour:
- Windows are combinational from the inputs, evaluated each cycle:
  - trace_win = (hpos >= H_VIEW) && (vpos < V_VIEW-1 || vpos == V_MAX)
  - cfg_win = (vpos >= V_VIEW) && !(vpos == V_MAX && hpos >= H_VIEW)
  - The two windows are mutually exclusive by construction.
- All outputs are registered: a response to input state in cycle n appears in cycle n+1.
- Reset values:
  - tr_gnt, cfg_gnt, tr_abort, cfg_abort, line_start, frame_end = 0
  - next_line = 0; overrun_count = 0
  - FSM = IDLE
- Sequencing pulses:
  - line_start = 1 for the cycle after hpos == H_VIEW with trace_win true.
  - next_line loads (vpos == V_MAX) ? 0 : vpos+1 on that same edge.
  - frame_end = 1 for the cycle after hpos == 0 && vpos == V_VIEW.
- FSM states: IDLE, TRACE, CFG.
- IDLE:
  - tr_req && trace_win -> TRACE; tr_gnt=1 next cycle.
  - Else cfg_req && cfg_win -> CFG; cfg_gnt=1 next cycle.
  - Tracer has priority if both qualify; by construction only one window is ever open.
  - Requests outside their window wait; no error is raised.
- TRACE:
  - tr_req low -> IDLE, tr_gnt=0 next cycle (normal release).
  - Else trace_win false (line wrapped to hpos 0) -> IDLE, tr_gnt=0, tr_abort=1 for one cycle, overrun_count += 1, saturating at 255.
  - Release wins if tr_req drops in the same cycle the window closes: no abort.
- CFG:
  - cfg_req low -> IDLE, cfg_gnt=0.
  - Else cfg_win false -> IDLE, cfg_gnt=0, cfg_abort=1. overrun_count is unchanged.
- After any release or abort the FSM spends at least one cycle in IDLE with both grants low. This is a bus-turnaround cycle, so a new grant appears no earlier than 2 cycles after the drop.
- Grants are never both high.
- An aborted requester that keeps its request high is re-granted only when its window next opens.
- Reset mid-grant: all grants low on the next cycle, no abort pulse, counter cleared.
- Arithmetic:
  - next_line is 10-bit unsigned.
  - overrun_count saturates and never wraps.

Test Plan:
- Reset, then free-run the timing generator one full frame:
  - line_start pulses exactly 480 times: vpos 0..478 plus 524;
  - next_line sequences 1..479 then 0;
  - frame_end pulses once, at cycle after (hpos 0, vpos 480).
- Normal trace:
  - tr_req rises at hpos 640 on vpos 10 -> tr_gnt=1 the cycle after the request is seen.
  - tr_req drops at hpos 700 -> tr_gnt=0 the next cycle; no tr_abort; overrun_count stays 0.
- Trace overrun:
  - hold tr_req high through hpos 799 -> tr_gnt=0 and tr_abort=1 the cycle after hpos 0, overrun_count=1.
  - Repeat 300 lines -> overrun_count=255.
- Config arbitration:
  - cfg_req high at vpos 100 -> no grant until the cycle after (hpos 0, vpos 480).
  - Hold through (vpos 524, hpos 640) -> cfg_abort=1 with cfg_gnt=0.
  - tr_req also held high -> tr_gnt=1 one idle cycle later; grants never overlap.
- Release/close race:
  - tr_req drops in the exact cycle hpos wraps to 0 -> no tr_abort, counter unchanged.
  - New tr_req right after a release -> grant no earlier than 2 cycles after the drop.
- Reset during tr_gnt=1 at vpos 50, hpos 660:
  - grants low the next cycle, no abort;
  - overrun_count=0, next_line=0.
